// File: rtl/sum_accumulator_if.sv
// Handshake bundle between the adder-side producer, the accumulator and the block-sum consumer.
// The producer/consumer side uses the master modport and the accumulator uses the slave modport.
interface sum_accumulator_if #(
  parameter int N     = 4,
  parameter int ACC_W = 8
);
  logic [N:0]       in_total;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_sat;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_total, in_valid, out_ready,
    input  in_ready, out_sum, out_sat, out_valid
  );

  modport slave (
    input  in_total, in_valid, out_ready,
    output in_ready, out_sum, out_sat, out_valid
  );
endinterface

// File: rtl/sum_accumulator.sv
// Saturating block accumulator: sums COUNT adder results, then holds the block sum
// on a valid/ready port until it is taken, and then starts the next block.
module sum_accumulator #(
  parameter int N     = 4,
  parameter int COUNT = 8,
  parameter int ACC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  sum_accumulator_if.slave   bus
);
  localparam int CNT_W = $clog2(COUNT + 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [CNT_W-1:0] cnt_q;
  logic             sat_q;
  logic             sat_d;
  logic [ACC_W-1:0] out_sum_q;
  logic             out_sat_q;
  logic             out_valid_q;
  logic [ACC_W:0]   sum_full;
  logic             accept;
  logic             last;

  assign bus.in_ready  = (state_q == ACCUM) && !clear && rst_n;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_valid = out_valid_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign last   = (cnt_q == CNT_W'(COUNT - 1));

  // The extra top bit of the full-width sum flags overflow; an all-ones acc stays pinned.
  always_comb begin
    sum_full = {1'b0, acc_q} + (ACC_W + 1)'(bus.in_total);
    acc_d    = sum_full[ACC_W-1:0];
    sat_d    = sat_q;
    if (sum_full[ACC_W]) begin
      acc_d = '1;
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_sum_q   <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (clear) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            if (last) begin
              out_sum_q   <= acc_d;
              out_sat_q   <= sat_d;
              out_valid_q <= 1'b1;
              state_q     <= HOLD;
              acc_q       <= '0;
              cnt_q       <= '0;
              sat_q       <= 1'b0;
            end else begin
              acc_q <= acc_d;
              sat_q <= sat_d;
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end
endmodule

// File: tb/tb_sum_accumulator.sv
// Drives an 8-bit and a 7-bit accumulator with identical stimulus and compares both
// against a block-level model that keeps the accepted samples of each block in a queue.
module tb_sum_accumulator;
  localparam int N     = 4;
  localparam int COUNT = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;

  always #5 clk = ~clk;

  sum_accumulator_if #(.N(N), .ACC_W(8)) bus8 ();
  sum_accumulator_if #(.N(N), .ACC_W(7)) bus7 ();

  sum_accumulator #(.N(N), .COUNT(COUNT), .ACC_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus8)
  );
  sum_accumulator #(.N(N), .COUNT(COUNT), .ACC_W(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus7)
  );

  int compared   = 0;
  int mismatched = 0;

  // Model: samples of the open block, plus the pending result for each width.
  int blockQ[$];
  bit mPending = 1'b0;
  int mSum8    = 0;
  int mSum7    = 0;
  bit mSat8    = 1'b0;
  bit mSat7    = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic void closeBlock();
    int total;
    total = 0;
    foreach (blockQ[i]) total += blockQ[i];
    mSum8 = (total > 255) ? 255 : total;
    mSat8 = (total > 255);
    mSum7 = (total > 127) ? 127 : total;
    mSat7 = (total > 127);
    blockQ.delete();
    mPending = 1'b1;
  endfunction

  task automatic sampleOutputs();
    checkOutput("out_valid8", bus8.out_valid, mPending);
    checkOutput("out_valid7", bus7.out_valid, mPending);
    if (mPending) begin
      checkOutput("out_sum8", bus8.out_sum, mSum8);
      checkOutput("out_sat8", bus8.out_sat, mSat8);
      checkOutput("out_sum7", bus7.out_sum, mSum7);
      checkOutput("out_sat7", bus7.out_sat, mSat7);
    end
  endtask

  // One clock cycle: entered just after a falling edge, leaves just after the next one.
  task automatic applyStimulus(input bit v, input int t, input bit r, input bit c);
    bit expReady;
    bus8.in_valid  = v;
    bus7.in_valid  = v;
    bus8.in_total  = 5'(t);
    bus7.in_total  = 5'(t);
    bus8.out_ready = r;
    bus7.out_ready = r;
    clear          = c;
    #1;
    expReady = !mPending && !c;
    checkOutput("in_ready8", bus8.in_ready, expReady);
    checkOutput("in_ready7", bus7.in_ready, expReady);
    @(posedge clk);
    if (c) begin
      blockQ.delete();
      mPending = 1'b0;
    end else if (!mPending) begin
      if (v) begin
        blockQ.push_back(t);
        if (blockQ.size() == COUNT) closeBlock();
      end
    end else if (r) begin
      mPending = 1'b0;
    end
    @(negedge clk);
    sampleOutputs();
  endtask

  task automatic checkResetOutputs(input string phase);
    checkOutput({phase, "_in_ready8"}, bus8.in_ready, 1'b0);
    checkOutput({phase, "_in_ready7"}, bus7.in_ready, 1'b0);
    checkOutput({phase, "_out_valid8"}, bus8.out_valid, 1'b0);
    checkOutput({phase, "_out_sum8"}, bus8.out_sum, 0);
    checkOutput({phase, "_out_sat8"}, bus8.out_sat, 1'b0);
    checkOutput({phase, "_out_valid7"}, bus7.out_valid, 1'b0);
    checkOutput({phase, "_out_sum7"}, bus7.out_sum, 0);
    checkOutput({phase, "_out_sat7"}, bus7.out_sat, 1'b0);
  endtask

  initial begin
    bus8.in_valid  = 1'b0;
    bus7.in_valid  = 1'b0;
    bus8.in_total  = '0;
    bus7.in_total  = '0;
    bus8.out_ready = 1'b0;
    bus7.out_ready = 1'b0;
    #1;
    checkResetOutputs("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Plain block of 3s; the trailing idle cycle is the output handshake.
    for (int i = 0; i < COUNT; i++) applyStimulus(1'b1, 3, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);

    // 31s saturate the 7-bit instance only; then a small block clears the flag.
    for (int i = 0; i < COUNT; i++) applyStimulus(1'b1, 31, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < COUNT; i++) applyStimulus(1'b1, 1, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);

    // Backpressure: result held while in_valid keeps offering samples.
    for (int i = 1; i <= COUNT; i++) applyStimulus(1'b1, i, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, $urandom_range(0, 31), 1'b0, 1'b0);
    applyStimulus(1'b1, 9, 1'b1, 1'b0);
    for (int i = 0; i < COUNT; i++) applyStimulus(1'b1, 4, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);

    // Clear coinciding with the fourth sample, then a full block.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2, 1'b1, 1'b0);
    applyStimulus(1'b1, 2, 1'b1, 1'b1);
    for (int i = 0; i < COUNT; i++) applyStimulus(1'b1, 2, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);

    // Clear while a result is pending discards it.
    for (int i = 0; i < COUNT; i++) applyStimulus(1'b1, 5, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);

    // Asynchronous reset between edges in the middle of a block.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 7, 1'b1, 1'b0);
    bus8.in_valid = 1'b0;
    bus7.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("async");
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    blockQ.delete();
    mPending = 1'b0;
    #1;
    checkOutput("post_reset_in_ready8", bus8.in_ready, 1'b1);
    @(negedge clk);
    for (int i = 0; i < COUNT; i++) applyStimulus(1'b1, 1, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);

    // Gapped input: valid on every other cycle.
    for (int i = 0; i < 2 * COUNT; i++) applyStimulus((i % 2) == 0, 16, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);

    // Random traffic with occasional clears and backpressure.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 31),
                    $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
